// File: rtl/lsu_mem_master.sv
// Purpose: RV32I load/store unit turning byte/half/word accesses into whole-word block-RAM operations.
// Latency: loads respond 2 cycles after accept; SW writes 1 cycle after accept; SB/SH read-modify-write in 3 cycles.
// Backpressure: busy is high whenever state != IDLE; requests are sampled only in IDLE, so the MEM stage must stall on busy.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   req_valid/store/funct3/addr/wdata/rd   request from the MEM stage (captured on the accepting edge)
//   busy                            operation in flight
//   resp_valid/resp_data/resp_rd    formatted load result (data/rd hold their last value between responses)
//   store_done                      pulse in the cycle the memory write is issued
//   fault                           pulse after a misaligned address or illegal funct3 was rejected
//   mem_is_load/mem_is_store/mem_addr/mem_store_data/mem_load_data   word-addressed memory port
module lsu_mem_master #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        store_done,
    output logic        fault,
    output logic        mem_is_load,
    output logic        mem_is_store,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store_data,
    input  logic [31:0] mem_load_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LRESP = 3'd2,
        S_MERGE = 3'd3,
        S_WR    = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Captured request. Only the address bits that reach the memory or pick a lane are kept.
    logic                  store_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [4:0]            rd_q;
    logic [31:0]           wdata_q;
    // Word to be written: req_wdata for SW, the merged word for SB/SH.
    logic [31:0]           word_q;
    logic                  fault_q;
    logic [31:0]           resp_data_q;
    logic [4:0]            resp_rd_q;

    // Address bits above the memory's word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    logic accept;
    logic req_bad;
    logic [31:0] load_fmt;
    logic [31:0] merged;
    logic [31:0] word_index;

    assign accept = (state_q == S_IDLE) && req_valid;

    // Accept-time legality: illegal funct3 or an address not aligned to the access size.
    always_comb begin
        req_bad = 1'b0;
        if (req_store) begin
            case (req_funct3)
                3'b000:  req_bad = 1'b0;
                3'b001:  req_bad = req_addr[0];
                3'b010:  req_bad = (req_addr[1:0] != 2'b00);
                default: req_bad = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: req_bad = 1'b0;
                3'b001, 3'b101: req_bad = req_addr[0];
                3'b010:         req_bad = (req_addr[1:0] != 2'b00);
                default:        req_bad = 1'b1;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !req_bad) begin
                    // Only a full-word store can skip the read.
                    if (req_store && (req_funct3 == 3'b010))
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:    state_d = store_q ? S_MERGE : S_LRESP;
            S_LRESP: state_d = S_IDLE;
            S_MERGE: state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Load formatting: lane selection by address, then sign or zero extension by funct3.
    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte = mem_load_data[7:0];
        case (addr_q[1:0])
            2'd0: sel_byte = mem_load_data[7:0];
            2'd1: sel_byte = mem_load_data[15:8];
            2'd2: sel_byte = mem_load_data[23:16];
            2'd3: sel_byte = mem_load_data[31:24];
            default: sel_byte = mem_load_data[7:0];
        endcase
        sel_half = addr_q[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_fmt = {24'd0, sel_byte};
            3'b101:  load_fmt = {16'd0, sel_half};
            default: load_fmt = mem_load_data;
        endcase
    end

    // Read-modify-write merge: drop the store data into the addressed lane(s) of the read word.
    always_comb begin
        merged = mem_load_data;
        if (funct3_q == 3'b001) begin
            if (addr_q[1])
                merged[31:16] = wdata_q[15:0];
            else
                merged[15:0] = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_load_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            rd_q        <= 5'd0;
            wdata_q     <= 32'd0;
            word_q      <= 32'd0;
            fault_q     <= 1'b0;
            resp_data_q <= 32'd0;
            resp_rd_q   <= 5'd0;
        end else begin
            // Rejected requests leave the captured registers untouched.
            fault_q <= accept && req_bad;
            if (accept && !req_bad) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[ADDR_WIDTH+1:0];
                rd_q     <= req_rd;
                wdata_q  <= req_wdata;
                word_q   <= req_wdata;
            end
            if (state_q == S_MERGE)
                word_q <= merged;
            if (state_q == S_LRESP) begin
                resp_data_q <= load_fmt;
                resp_rd_q   <= rd_q;
            end
        end
    end

    assign word_index = {{(32 - ADDR_WIDTH){1'b0}}, addr_q[ADDR_WIDTH+1:2]};

    assign busy           = (state_q != S_IDLE);
    assign mem_is_load    = (state_q == S_RD);
    assign mem_is_store   = (state_q == S_WR);
    assign store_done     = (state_q == S_WR);
    assign mem_addr       = ((state_q == S_RD) || (state_q == S_WR)) ? word_index : 32'd0;
    assign mem_store_data = (state_q == S_WR) ? word_q : 32'd0;
    assign fault          = fault_q;

    // The live value is shown during LRESP; afterwards the registered copy holds it.
    assign resp_valid = (state_q == S_LRESP);
    assign resp_data  = (state_q == S_LRESP) ? load_fmt : resp_data_q;
    assign resp_rd    = (state_q == S_LRESP) ? rd_q : resp_rd_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Purpose: self-checking bench for lsu_mem_master with a word RAM model and response/store scoreboards.
// Latency: RAM model returns read data one cycle after mem_is_load.
// Backpressure: requests are only driven while the DUT is idle; waits are bounded by cycle budgets.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        store_done;
    logic        fault;
    logic        mem_is_load;
    logic        mem_is_store;
    logic [31:0] mem_addr;
    logic [31:0] mem_store_data;
    logic [31:0] mem_load_data = 32'd0;

    lsu_mem_master #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .busy(busy), .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .store_done(store_done), .fault(fault),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .mem_addr(mem_addr), .mem_store_data(mem_store_data),
        .mem_load_data(mem_load_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];

    always @(posedge clk) begin
        if (mem_is_load)  mem_load_data <= mem[mem_addr[11:0]];
        if (mem_is_store) mem[mem_addr[11:0]] <= mem_store_data;
    end

    typedef struct { logic [31:0] data; logic [4:0] rd; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    int nvec = 0;
    int nerr = 0;
    int ld_cnt = 0, st_cnt = 0, sd_cnt = 0, flt_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboards for responses and writes, strobe counters.
    always @(negedge clk) begin
        if (mem_is_load)  ld_cnt++;
        if (mem_is_store) st_cnt++;
        if (store_done)   sd_cnt++;
        if (fault)        flt_cnt++;
        if (mem_is_load || mem_is_store)
            check("strobe_exclusive", {31'd0, mem_is_load & mem_is_store}, 32'd0);
        if (resp_valid) begin
            if (rsp_q.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_rd", {27'd0, resp_rd}, {27'd0, e.rd});
            end
        end
        if (mem_is_store) begin
            if (wr_q.size() == 0) begin
                check("write_unexpected", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("write_addr", mem_addr, w.addr);
                check("write_data", mem_store_data, w.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
    endtask

    // Drive a request, let the accepting edge pass, then withdraw it.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        drive(st, f3, a, wd, rd);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] ctl_vec();
        return {26'd0, busy, resp_valid, store_done, fault, mem_is_load, mem_is_store};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Load test table on mem[4] = 0x80FF1234.
    logic [2:0]  lt_f3   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] lt_addr [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] lt_exp  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234};

    initial begin
        int b_ld, b_st, b_sd, b_flt;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;

        // Reset with a pending request.
        rst_n = 1'b0;
        drive(1'b0, 3'b010, 32'h10, 32'd0, 5'd5);
        tick(); tick();
        check("rst_ctl", ctl_vec(), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_store_data", mem_store_data, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        b_ld = ld_cnt; b_st = st_cnt;
        repeat (3) tick();
        check("idle_no_strobes", ld_cnt + st_cnt, b_ld + b_st);

        // LW 0x10 -> mem[4].
        rsp_q.push_back('{32'hDEADBEEF, 5'd5});
        issue(1'b0, 3'b010, 32'h10, 32'd0, 5'd5);
        check("lw_c1_load", {31'd0, mem_is_load}, 32'd1);
        check("lw_c1_addr", mem_addr, 32'd4);
        check("lw_c1_busy", {31'd0, busy}, 32'd1);
        tick();
        check("lw_c2_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("lw_c2_busy", {31'd0, busy}, 32'd1);
        tick();
        check("lw_c3_ctl", ctl_vec(), 32'd0);

        // Sub-word loads with sign/zero extension.
        mem[4] = 32'h80FF1234;
        for (int i = 0; i < 4; i++) begin
            rsp_q.push_back('{lt_exp[i], 5'(10 + i)});
            issue(1'b0, lt_f3[i], lt_addr[i], 32'd0, 5'(10 + i));
            wait_idle("subword_load_done");
        end

        // SB 0xAB at 0x21 -> read-modify-write of mem[8].
        b_sd = sd_cnt;
        wr_q.push_back('{32'd8, 32'h1122AB44});
        issue(1'b1, 3'b000, 32'h21, 32'h000000AB, 5'd0);
        check("sb_rd_load", {31'd0, mem_is_load}, 32'd1);
        check("sb_rd_addr", mem_addr, 32'd8);
        tick();
        check("sb_merge_ctl", ctl_vec(), 32'h20);
        tick();
        check("sb_wr_ctl", ctl_vec(), 32'h29);
        check("sb_wr_addr", mem_addr, 32'd8);
        check("sb_wr_data", mem_store_data, 32'h1122AB44);
        tick();
        check("sb_done_idle", {31'd0, busy}, 32'd0);
        check("sb_mem_word", mem[8], 32'h1122AB44);
        check("sb_single_store_done", sd_cnt - b_sd, 32'd1);

        // SW 0x20: single write cycle, no read.
        b_ld = ld_cnt;
        wr_q.push_back('{32'd8, 32'hCAFEF00D});
        issue(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 5'd0);
        check("sw_c1_ctl", ctl_vec(), 32'h29);
        check("sw_c1_data", mem_store_data, 32'hCAFEF00D);
        tick();
        check("sw_c2_busy", {31'd0, busy}, 32'd0);
        check("sw_no_read", ld_cnt - b_ld, 32'd0);
        check("sw_mem_word", mem[8], 32'hCAFEF00D);

        // Misaligned LW, then a valid LW accepted immediately.
        mem[4] = 32'hDEADBEEF;
        b_ld = ld_cnt; b_st = st_cnt; b_flt = flt_cnt;
        issue(1'b0, 3'b010, 32'h06, 32'd0, 5'd3);
        check("mis_lw_ctl", ctl_vec(), 32'h04);
        rsp_q.push_back('{32'hDEADBEEF, 5'd7});
        issue(1'b0, 3'b010, 32'h10, 32'd0, 5'd7);
        check("after_mis_ctl", ctl_vec(), 32'h22);
        wait_idle("after_mis_done");

        // Illegal load funct3 011, then a valid LBU.
        issue(1'b0, 3'b011, 32'h10, 32'd0, 5'd3);
        check("ill_ld_ctl", ctl_vec(), 32'h04);
        rsp_q.push_back('{32'h000000EF, 5'd8});
        issue(1'b0, 3'b100, 32'h10, 32'd0, 5'd8);
        check("after_ill_ctl", ctl_vec(), 32'h22);
        wait_idle("after_ill_done");

        // Illegal store funct3 101 and misaligned SH.
        issue(1'b1, 3'b101, 32'h20, 32'h1, 5'd0);
        check("ill_st_ctl", ctl_vec(), 32'h04);
        issue(1'b1, 3'b001, 32'h21, 32'h1, 5'd0);
        check("mis_sh_ctl", ctl_vec(), 32'h04);
        tick();
        check("fault_pulses", flt_cnt - b_flt, 32'd4);
        check("fault_loads", ld_cnt - b_ld, 32'd2);
        check("fault_no_store", st_cnt - b_st, 32'd0);

        // Reset during MERGE of an SH.
        b_st = st_cnt;
        issue(1'b1, 3'b001, 32'h22, 32'h00005566, 5'd0);
        tick();
        check("sh_in_merge", ctl_vec(), 32'h20);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", ctl_vec(), 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("mid_rst_no_store", st_cnt - b_st, 32'd0);
        check("mid_rst_mem_word", mem[8], 32'hCAFEF00D);
        rsp_q.push_back('{32'hCAFEF00D, 5'd9});
        issue(1'b0, 3'b010, 32'h20, 32'd0, 5'd9);
        check("post_rst_load", {31'd0, mem_is_load}, 32'd1);
        wait_idle("post_rst_done");
        tick();

        check("resp_queue_drained", rsp_q.size(), 32'd0);
        check("write_queue_drained", wr_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
